// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command-side master for the 32-bit ALU
// Accepts one op per handshake, launches it, waits for done or timeout, returns the response.
module alu_cmd_issuer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_hi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [3:0]       rsp_flag,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_num_1,
  output logic [WIDTH-1:0] alu_num_2,
  output logic [WIDTH-1:0] alu_sub_reg_input,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_sub_reg_result,
  input  logic             alu_done,
  input  logic [3:0]       alu_flag
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] OP_PARK = 4'hF;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MAX  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] num_1_q, num_1_d;
  logic [WIDTH-1:0] num_2_q, num_2_d;
  logic [WIDTH-1:0] sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       flag_q, flag_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             timeout_hit;

  assign cmd_ready   = (state_q == S_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= OP_PARK;
      alu_opcode_q <= OP_PARK;
      num_1_q      <= '0;
      num_2_q      <= '0;
      sub_q        <= '0;
      res_q        <= '0;
      hi_q         <= '0;
      flag_q       <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      alu_opcode_q <= alu_opcode_d;
      num_1_q      <= num_1_d;
      num_2_q      <= num_2_d;
      sub_q        <= sub_d;
      res_q        <= res_d;
      hi_q         <= hi_d;
      flag_q       <= flag_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (cmd_opcode > OP_MAX) ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (alu_done || timeout_hit) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    num_1_d = num_1_q;
    num_2_d = num_2_q;
    sub_d   = sub_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flag_d  = flag_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_opcode;
          num_1_d = cmd_a;
          num_2_d = cmd_b;
          sub_d   = cmd_hi;
          if (cmd_opcode > OP_MAX) begin
            res_d  = '0;
            hi_d   = '0;
            flag_d = 4'hF;
            err_d  = 1'b1;
          end
        end
      end
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (alu_done) begin
          res_d  = alu_result;
          flag_d = alu_flag;
          hi_d   = (op_q == OP_MUL || op_q == OP_DIV) ? alu_sub_reg_result : '0;
          err_d  = 1'b0;
        end else if (timeout_hit) begin
          res_d  = '0;
          hi_d   = '0;
          flag_d = 4'hF;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    alu_opcode_d = (state_d == S_LAUNCH || state_d == S_WAIT) ? op_d : OP_PARK;
    valid_d      = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  assign rsp_valid         = valid_q;
  assign rsp_result        = res_q;
  assign rsp_hi            = hi_q;
  assign rsp_flag          = flag_q;
  assign rsp_err           = err_q;
  assign busy              = busy_q;
  assign alu_num_1         = num_1_q;
  assign alu_num_2         = num_2_q;
  assign alu_sub_reg_input = sub_q;
  assign alu_opcode        = alu_opcode_q;

endmodule
